muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on the clk edge.
REQ-005 SHALL have port op  input  2  operation: 00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div; sampled with start.
REQ-006 SHALL have port src_a  input  WIDTH  multiplicand or dividend; sampled with start.
REQ-007 SHALL have port src_b  input  WIDTH  multiplier or divisor; sampled with start.
REQ-008 SHALL have port wr_hi  input  1  move-to-HI strobe.
REQ-009 SHALL have port wr_lo  input  1  move-to-LO strobe.
REQ-010 SHALL have port wdata  input  WIDTH  data for wr_hi / wr_lo.
REQ-011 SHALL have port busy  output  1  operation in progress; the hazard unit stalls on this.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port div_by_zero  output  1  qualifies done; divide with src_b == 0.
REQ-014 SHALL have port hi  output  WIDTH  HI register.
REQ-015 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-016 SHALL implement FSM states IDLE, CALC and FIX.
- IDLE -> CALC on start.
- CALC -> FIX after exactly WIDTH iterations (counter of clog2(WIDTH)+1 bits).
- FIX -> IDLE unconditionally.
REQ-017 SHALL, in IDLE with start=1, capture op and the operands; for signed ops it SHALL store operand magnitudes and result-sign flags.
REQ-018 SHALL perform one shift-add multiply step or one restoring-divide step per CALC cycle.
REQ-019 SHALL, in FIX, apply sign correction and load hi/lo; done SHALL be registered so it goes high in the cycle the FSM returns to IDLE.
REQ-020 SHALL assert done for exactly one cycle, WIDTH+2 edges after the edge that sampled start; hi/lo SHALL be valid in that same cycle.
REQ-021 SHALL drive busy = 1 exactly while in CALC or FIX (WIDTH+1 cycles); busy SHALL be 0 during the done cycle.
REQ-022 SHALL accept start in the done cycle (back-to-back issue, no bubble).
REQ-023 SHALL ignore start while busy; the operation in flight SHALL be unaffected.
REQ-024 Multiply SHALL produce {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
REQ-025 Divide SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-026 Divide by zero SHALL complete with normal latency, lo = all ones, hi = src_a, and div_by_zero = 1 coincident with done; div_by_zero SHALL be 0 for every other operation.
REQ-027 Signed divide of most-negative by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-028 wr_hi/wr_lo SHALL update hi/lo from wdata on the next edge when busy=0; both strobes together SHALL write both registers.
REQ-029 wr_hi/wr_lo SHALL be ignored while busy=1.
REQ-030 wr_hi/wr_lo together with start in the same IDLE cycle SHALL both take effect; the later operation result then overwrites hi/lo.
REQ-031 hi/lo SHALL hold their value at all other times.

Reset
REQ-032 SHALL, on reset low at any time (including mid-CALC or FIX), go immediately to IDLE and clear the counter.
REQ-033 SHALL drive hi=0, lo=0, busy=0, done=0 and div_by_zero=0 while reset is low.
REQ-034 SHALL produce no done pulse for an aborted operation.
REQ-035 SHALL accept start on the first edge after reset deassertion.

Verification (WIDTH=32)
REQ-036 Signed mult -3 * 5 -> done at edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high edges 1..33.
REQ-037 Unsigned mult 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start again in the done cycle with 2*3 -> hi=0, lo=6 exactly 34 edges later.
REQ-038 Signed div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 Unsigned div 7 / 0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 for one cycle with done.
REQ-040 Mid-operation and strobe checks:
- Reset low at edge 10 of a mult -> hi=lo=0, busy=0, no done.
- start pulsed at edge 5 of a busy op -> ignored.
- wr_hi with 0x1234 while busy -> ignored.
- wr_hi with 0x1234 while idle -> hi=0x1234 next edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: WIDTH shift-add or
// restoring-divide steps on operand magnitudes, then one cycle of sign correction.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             dz;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    // Operand conditioning: op[0]=0 selects the signed variants.
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & src_a[WIDTH-1];
    assign b_neg     = is_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag     = b_neg ? (~src_b + 1'b1) : src_b;

    // One iteration of each algorithm; acc_hi holds the partial product / remainder.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_r};
    assign div_ok    = ~div_diff[WIDTH];

    // Final results; the remainder keeps the dividend's sign so a divide by zero
    // naturally returns src_a in hi.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_lo ? (~prod + 1'b1) : prod;

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
            if (dz) begin
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_lo = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            b_r         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (start) begin
                        is_div <= op[1];
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        dz     <= op[1] & (src_b == '0);
                        b_r    <= b_mag;
                        acc_hi <= '0;
                        acc_lo <= a_mag;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32: table of operations with
// hand-computed results, then hand sequences for strobes, busy-time starts and reset abort.
module tb_muldiv_unit;

    localparam int W       = 32;
    localparam int DONE_AT = W + 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start is raised immediately, so calling this from a done cycle issues back-to-back.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
    endtask

    // Negedge n sees the value present at edge n (edge 0 sampled start).
    task automatic wait_done(input int first_n, output int dn, output int busy_bad);
        dn       = -1;
        busy_bad = 0;
        for (int n = first_n; n <= DONE_AT + 6; n++) begin
            @(negedge clk);
            if (busy !== (n <= W + 1)) busy_bad++;
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        int dn;
        int bb;
        launch(vecs[i].op, vecs[i].a, vecs[i].b);
        wait_done(1, dn, bb);
        chk({vecs[i].name, "_latency"}, 64'(dn), 64'(DONE_AT));
        chk({vecs[i].name, "_busy"}, 64'(bb), 64'd0);
        chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
        chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
        chk({vecs[i].name, "_dz"}, 64'(div_by_zero), 64'(vecs[i].dz));
    endtask

    initial begin
        int dn;
        int bb;
        int ndone;

        vecs[0]  = '{"smul_m3x5",      2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1]  = '{"umul_max",       2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        // Issued in the done cycle of the previous vector.
        vecs[2]  = '{"umul_2x3_b2b",   2'b01, 32'd2,        32'd3,        32'h0,        32'd6,        1'b0};
        vecs[3]  = '{"sdiv_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{"sdiv_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[5]  = '{"udiv_7_0",       2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{"smul_min_min",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
        vecs[7]  = '{"smul_max_m1",    2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        vecs[8]  = '{"udiv_100_7",     2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[9]  = '{"sdiv_7_m2",      2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[10] = '{"sdiv_m5_0",      2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{"udiv_max_1",     2'b11, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[12] = '{"umul_x16",       2'b01, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_hi",   64'(hi), 64'd0);
        chk("rst_lo",   64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(div_by_zero), 64'd0);

        // First start is sampled on the first edge after reset release.
        reset = 1'b1;
        for (int i = 0; i < 13; i++) run_vec(i);

        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        wr_hi = 1'b1;
        wdata = 32'h1234;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        chk("wr_hi_idle_hi", 64'(hi), 64'h1234);
        chk("wr_hi_idle_lo", 64'(lo), 64'h23456780);

        @(negedge clk);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("wr_both_hi", 64'(hi), 64'hCAFEF00D);
        chk("wr_both_lo", 64'(lo), 64'hCAFEF00D);

        // Strobe and start together: the write lands first, the result later overwrites.
        @(negedge clk);
        wr_lo = 1'b1;
        wdata = 32'hAAAA;
        launch(2'b01, 32'd3, 32'd4);
        chk("wr_start_lo", 64'(lo), 64'hAAAA);
        chk("wr_start_hi", 64'(hi), 64'hCAFEF00D);
        wait_done(1, dn, bb);
        chk("wr_start_latency", 64'(dn), 64'(DONE_AT));
        chk("wr_start_res_hi", 64'(hi), 64'd0);
        chk("wr_start_res_lo", 64'(lo), 64'd12);

        // Start and wr_hi presented at edge 5 of a busy operation.
        launch(2'b01, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        src_a = 32'd100;
        src_b = 32'd0;
        wr_hi = 1'b1;
        wdata = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        chk("wr_hi_busy_ignored", 64'(hi), 64'd0);
        wait_done(6, dn, bb);
        chk("busy_start_latency", 64'(dn), 64'(DONE_AT));
        chk("busy_start_busy", 64'(bb), 64'd0);
        chk("busy_start_lo", 64'(lo), 64'd42);
        chk("busy_start_hi", 64'(hi), 64'd0);
        chk("busy_start_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        chk("busy_start_no_2nd_op", 64'(busy), 64'd0);

        // Abort a multiply at edge 10.
        launch(2'b00, 32'hFFFFFFFD, 32'd5);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_hi",   64'(hi), 64'd0);
        chk("abort_lo",   64'(lo), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        launch(2'b11, 32'd100, 32'd7);
        wait_done(1, dn, bb);
        chk("post_abort_latency", 64'(dn), 64'(DONE_AT));
        chk("post_abort_hi", 64'(hi), 64'd2);
        chk("post_abort_lo", 64'(lo), 64'd14);

        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("idle_no_done", 64'(ndone), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
